// File: rtl/filter_unfold_serializer.sv
// filter_unfold_serializer
// Buffers sample triplets from the 3-way unfolded IIR output bus in a small
// FIFO and replays them one sample per ready/valid transfer, oldest lane first.
//
// state | meaning
// LANE0 | DOUT shows head sample 3k (also the idle state when COUNT=0)
// LANE1 | DOUT shows head sample 3k+1
// LANE2 | DOUT shows head sample 3k+2; a transfer here pops the head entry
module filter_unfold_serializer #(
  parameter int NBIT  = 16,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   VIN,
  input  logic [NBIT-1:0]        DIN3k,
  input  logic [NBIT-1:0]        DIN3k1,
  input  logic [NBIT-1:0]        DIN3k2,
  input  logic                   READY,
  output logic [NBIT-1:0]        DOUT,
  output logic                   VOUT,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2
  } lane_t;

  logic [3*NBIT-1:0] mem [DEPTH];
  logic [3*NBIT-1:0] head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  lane_t             lane;
  logic              xfer;
  logic              pop;
  logic              full;
  logic              push;
  logic              drop;

  assign VOUT = (COUNT != '0);
  assign full = (COUNT == CW'(DEPTH));
  assign xfer = VOUT & READY;
  assign pop  = xfer & (lane == LANE2);
  // A pop in the same cycle frees the head slot, so a full FIFO still
  // accepts the incoming triplet; this makes READY combinationally gate push.
  assign push = VIN & (~full | pop);
  assign drop = VIN & full & ~pop;

  // Triplet storage; contents are simply abandoned on reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {DIN3k, DIN3k1, DIN3k2};
    end
  end

  // Show-ahead output: select the current lane of the head entry.
  always_comb begin
    head = mem[rd_ptr];
    DOUT = head[3*NBIT-1:2*NBIT];
    case (lane)
      LANE1:   DOUT = head[2*NBIT-1:NBIT];
      LANE2:   DOUT = head[NBIT-1:0];
      default: DOUT = head[3*NBIT-1:2*NBIT];
    endcase
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
      OVF    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   COUNT <= COUNT + CW'(1);
        2'b01:   COUNT <= COUNT - CW'(1);
        default: COUNT <= COUNT;
      endcase
      if (drop) begin
        OVF <= 1'b1;
      end
    end
  end

  // Lane state machine: advances only on an accepted transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lane <= LANE0;
    end else if (xfer) begin
      case (lane)
        LANE0:   lane <= LANE1;
        LANE1:   lane <= LANE2;
        default: lane <= LANE0;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_unfold_serializer.sv
// Directed bench for filter_unfold_serializer: vector table for the basic,
// backpressure and overflow cases, hand sequences for the rest.
module tb_filter_unfold_serializer;

  localparam int NBIT  = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            CLK = 1'b0;
  logic            RST;
  logic            VIN;
  logic [NBIT-1:0] DIN3k, DIN3k1, DIN3k2;
  logic            READY;
  logic [NBIT-1:0] DOUT;
  logic            VOUT;
  logic [CW-1:0]   COUNT;
  logic            OVF;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic            vin;
    logic [NBIT-1:0] d0, d1, d2;
    logic            rdy;
    logic            e_vout;
    logic [NBIT-1:0] e_dout;
    logic [CW-1:0]   e_count;
    logic            e_ovf;
  } vec_t;

  vec_t vecs[$];
  logic [NBIT-1:0] sb[$];
  logic [NBIT-1:0] exp4[12];

  always #5 CLK = ~CLK;

  filter_unfold_serializer #(.NBIT(NBIT), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .VIN(VIN),
    .DIN3k(DIN3k), .DIN3k1(DIN3k1), .DIN3k2(DIN3k2),
    .READY(READY), .DOUT(DOUT), .VOUT(VOUT), .COUNT(COUNT), .OVF(OVF)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vin, input int d0, input int d1, input int d2,
                              input logic rdy, input logic ev, input int ed, input int ec,
                              input logic eo);
    vec_t v;
    v.vin = vin; v.d0 = NBIT'(d0); v.d1 = NBIT'(d1); v.d2 = NBIT'(d2);
    v.rdy = rdy; v.e_vout = ev; v.e_dout = NBIT'(ed); v.e_count = CW'(ec); v.e_ovf = eo;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are inspected 1 time unit later.
  task automatic drive(input logic vin, input int d0, input int d1, input int d2, input logic rdy);
    @(negedge CLK);
    VIN = vin; DIN3k = NBIT'(d0); DIN3k1 = NBIT'(d1); DIN3k2 = NBIT'(d2); READY = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; VIN = 1'b0; READY = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; VIN = 1'b0; READY = 1'b0;
    DIN3k = '0; DIN3k1 = '0; DIN3k2 = '0;

    // single triplet
    vecs.push_back(mk(1, 'h1, 'h2, 'h3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // backpressure, READY 1,0,0,1,1
    vecs.push_back(mk(1, 'hA00, 'hA01, 'hA02, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'hA00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'hA01, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'hA01, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'hA01, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'hA02, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // overflow: five triplets with READY low, the fifth is dropped
    vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 4, 5, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 6, 7, 8, 0, 1, 0, 2, 0));
    vecs.push_back(mk(1, 9, 10, 11, 0, 1, 0, 3, 0));
    vecs.push_back(mk(1, 12, 13, 14, 0, 1, 0, 4, 0));
    for (int s = 0; s < 12; s++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, s, 4 - s / 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));

    #1;
    chk("rst_vout", 0, VOUT, 0);
    chk("rst_count", 0, COUNT, 0);
    chk("rst_ovf", 0, OVF, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vin, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].rdy);
      chk("tbl_vout", i, VOUT, vecs[i].e_vout);
      chk("tbl_count", i, COUNT, vecs[i].e_count);
      chk("tbl_ovf", i, OVF, vecs[i].e_ovf);
      if (vecs[i].e_vout) chk("tbl_dout", i, DOUT, vecs[i].e_dout);
    end

    // full FIFO, lane 2, transfer and push in the same cycle
    do_reset();
    for (int k = 0; k < 4; k++) drive(1, 'h100 + 3 * k, 'h101 + 3 * k, 'h102 + 3 * k, 0);
    drive(0, 0, 0, 0, 1);
    chk("full_cnt", 0, COUNT, 4);
    chk("full_dout", 0, DOUT, 'h100);
    drive(0, 0, 0, 0, 1);
    chk("full_dout", 1, DOUT, 'h101);
    drive(1, 'h200, 'h201, 'h202, 1);
    chk("full_dout", 2, DOUT, 'h102);
    chk("full_cnt", 2, COUNT, 4);
    for (int i = 0; i < 9; i++) exp4[i] = NBIT'('h103 + i);
    exp4[9] = 'h200; exp4[10] = 'h201; exp4[11] = 'h202;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0, 1);
      chk("fp_vout", i, VOUT, 1);
      chk("fp_dout", i, DOUT, exp4[i]);
      if (i == 0) begin
        chk("fp_cnt_after_pushpop", i, COUNT, 4);
        chk("fp_ovf", i, OVF, 0);
      end
    end
    drive(0, 0, 0, 0, 1);
    chk("fp_end_vout", 0, VOUT, 0);
    chk("fp_end_cnt", 0, COUNT, 0);
    chk("fp_end_ovf", 0, OVF, 0);

    // 1000 random triplets at duty 1/3, READY high, pointers wrap many times
    do_reset();
    begin
      int sent = 0;
      for (int c = 0; c < 3100; c++) begin
        logic v;
        logic [NBIT-1:0] a, b, d;
        v = (c % 3 == 0) && (sent < 1000);
        a = NBIT'($urandom); b = NBIT'($urandom); d = NBIT'($urandom);
        drive(v, a, b, d, 1);
        if (VOUT) begin
          if (sb.size() == 0) chk("wrap_unexpected_vout", c, 1, 0);
          else chk("wrap_dout", c, DOUT, sb.pop_front());
        end
        chk("wrap_ovf", c, OVF, 0);
        if (v) begin
          sb.push_back(a); sb.push_back(b); sb.push_back(d);
          sent++;
        end
      end
      chk("wrap_left", 0, sb.size(), 0);
      chk("wrap_end_vout", 0, VOUT, 0);
    end

    // asynchronous reset with lane=1, COUNT=3 and OVF already set
    do_reset();
    for (int k = 0; k < 5; k++) drive(1, 'h400 + 3 * k, 'h401 + 3 * k, 'h402 + 3 * k, 0);
    for (int s = 0; s < 4; s++) begin
      drive(0, 0, 0, 0, 1);
      chk("ar_dout", s, DOUT, 'h400 + s);
    end
    drive(0, 0, 0, 0, 0);
    chk("ar_pre_dout", 0, DOUT, 'h404);
    chk("ar_pre_cnt", 0, COUNT, 3);
    chk("ar_pre_ovf", 0, OVF, 1);
    #1 RST = 1'b1;
    #1;
    chk("ar_vout", 0, VOUT, 0);
    chk("ar_cnt", 0, COUNT, 0);
    chk("ar_ovf", 0, OVF, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    drive(0, 0, 0, 0, 1);
    drive(1, 'h500, 'h501, 'h502, 1);
    for (int s = 0; s < 3; s++) begin
      drive(0, 0, 0, 0, 1);
      chk("ar_new_vout", s, VOUT, 1);
      chk("ar_new_dout", s, DOUT, 'h500 + s);
    end
    drive(0, 0, 0, 0, 1);
    chk("ar_new_end", 0, VOUT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter_unfold_serializer.md
# filter_unfold_serializer

Output-side converter for the 3-way unfolded IIR filter. It accepts one triplet of samples (lanes 3k, 3k+1, 3k+2) per valid cycle on the filter's parallel output bus. It buffers triplets in a small FIFO and re-emits them as one sample per transfer, in time order, on a ready/valid serial stream. It sits between `myfilter` and any single-lane consumer: sample dumper, DAC model or serial checker.

## Interface
- `NBIT`, 16: sample width (two's complement, passed through untouched).
- `DEPTH`, 4: FIFO capacity in triplets; power of 2, ≥ 2.
- `CLK` in 1: single clock, all state updates on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `VIN` in 1: triplet valid; there is no backpressure toward the filter.
- `DIN3k` in NBIT: oldest sample of the triplet.
- `DIN3k1` in NBIT: middle sample.
- `DIN3k2` in NBIT: newest sample.
- `READY` in 1: downstream accepts `DOUT` this cycle.
- `DOUT` out NBIT: serial sample.
- `VOUT` out 1: `DOUT` valid.
- `COUNT` out clog2(DEPTH)+1: triplets currently stored, including the one being drained.
- `OVF` out 1: sticky overflow, meaning at least one triplet was dropped.

## Operation
- Storage:
  - `DEPTH`-entry array of 3×NBIT words.
  - Write pointer and read pointer, each clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `COUNT` register.
  - 2-bit lane counter `lane` ∈ {0,1,2}.
  - `OVF` flag.
- Push:
  - Condition: `VIN`=1 and (`COUNT`<DEPTH or pop occurs in the same cycle).
  - Action: write `{DIN3k,DIN3k1,DIN3k2}` at the write pointer, then increment the write pointer.
- Drop:
  - Condition: `VIN`=1, `COUNT`=DEPTH and no pop this cycle.
  - Action: discard the triplet and set `OVF`=1. `OVF` holds until `RST`.
- Serial output (show-ahead, no extra register stage):
  - `VOUT` = (`COUNT`≠0).
  - `DOUT` = head entry lane `lane`: 0→`DIN3k`, 1→`DIN3k1`, 2→`DIN3k2`.
- Transfer: occurs when `VOUT`=1 and `READY`=1.
  - If `lane`<2: `lane`++.
  - If `lane`=2: `lane`←0 and pop (read pointer++).
- `COUNT` next value:
  - +1 on push without pop.
  - −1 on pop without push.
  - Unchanged on push with pop, or when neither occurs.
- `DOUT` when `VOUT`=0: holds the last array/head value. This value is don't-care; benches must not check it.
- Reset: any `RST` assertion, including mid-triplet or mid-burst.
  - Pointers, `COUNT`, `lane` and `OVF` go to 0 immediately.
  - Stored data is abandoned; array contents need not be cleared.
- Lane state machine: IDLE/L0 → L1 → L2 → L0 (next entry) or IDLE (FIFO empty).
  - `lane` advances only on a transfer.
  - `READY`=0 freezes `lane` and `DOUT`.

## Timing
- Reset values:
  - `VOUT`=0, `COUNT`=0, `OVF`=0.
  - `DOUT` = array entry 0 lane 0: undefined after power-up, don't-care while `VOUT`=0.
- Latency:
  - A triplet pushed at edge t gives `VOUT`=1 and `DOUT`=`DIN3k` of that triplet in the cycle after edge t.
  - With `READY` held high, the three samples appear on three consecutive cycles.
- Throughput:
  - 1 sample/cycle out against up to 3 samples/cycle in.
  - Sustained `VIN` duty above 1/3 eventually overflows.
- Full-and-popping:
  - `COUNT`=DEPTH, `lane`=2 and a transfer occurs: the concurrent push is accepted and `COUNT` stays DEPTH.
  - This creates a combinational path `READY` → accept. It is intentional.
- Pointer wrap: pointers roll from DEPTH−1 to 0 without data loss.
- Empty-and-pushing: `COUNT`=0 with `VIN`=1 gives `VOUT`=1 only on the next cycle (no bypass).
- Async reset:
  - Takes effect without a clock edge.
  - Release is synchronised externally; the block requires `RST` deassertion ≥1 cycle before the first `VIN`.

## Test plan
1. Single triplet:
   - Stimulus: reset, then one `VIN` pulse with (0x0001, 0x0002, 0x0003), `READY`=1.
   - Required response: `DOUT` = 0x0001, 0x0002, 0x0003 on the next three cycles with `VOUT`=1, then `VOUT`=0 and `COUNT`=0.
2. Backpressure:
   - Stimulus: triplet (0x0A00, 0x0A01, 0x0A02); `READY` toggled 1,0,0,1,1.
   - Required response: `DOUT` holds 0x0A01 during both `READY`=0 cycles; output order unchanged; 3 transfers total.
3. Overflow (DEPTH=4):
   - Stimulus: `READY`=0; 5 consecutive `VIN` triplets with k=0..4 (values 3k..3k+2); then `READY`=1.
   - Required response: `COUNT`=4 and `OVF`=1 after the 5th; output stream is 0..11; triplet 12..14 absent; `OVF` stays 1.
4. Full with simultaneous pop/push:
   - Stimulus: FIFO full, `lane`=2, `READY`=1 and `VIN`=1 in the same cycle.
   - Required response: push accepted, `COUNT` stays 4, `OVF` stays 0, new triplet emitted last.
5. Wrap-around: 1000 random triplets at `VIN` duty 1/3 with `READY`=1 → serial stream equals the concatenated input lanes, `OVF`=0 throughout.
6. Reset mid-operation:
   - Stimulus: assert `RST` asynchronously while `lane`=1 and `COUNT`=3.
   - Required response: `VOUT`, `COUNT`, `OVF` at 0 before the next edge; after release, a new triplet starts at its `DIN3k` sample.
